morse_tx: RTL and testbench
===========================

MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 SHALL have parameter UNIT_DIV, default 5000000: clock cycles per Morse time unit (dot length); legal range 2..2^24-1.
REQ-002 SHALL have parameter CHAR_GAP, default 3: time units of key-off appended after every non-space character; legal range 0..15.
REQ-003 SHALL have parameter WORD_GAP, default 7: time units of key-off emitted for an all-zero code (space); legal range 1..15.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 code  input  24  right-aligned on/off pattern from the character encoder, one bit per time unit, 1 = key on.
REQ-007 code_valid  input  1  code is presented this cycle.
REQ-008 code_ready  output  1  block can accept a code this cycle.
REQ-009 key  output  1  keying output, 1 = tone/LED on.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, SEND, GAP.
REQ-012 code_ready SHALL equal 1 only in IDLE; a transfer occurs on a rising edge with code_valid=1 and code_ready=1.
REQ-013 On transfer with code!=0: SHALL latch code, set bit index to position of highest set bit, clear unit counter, enter SEND on the next cycle.
REQ-014 On transfer with code==0: SHALL enter GAP with gap count WORD_GAP.
REQ-015 In SEND, key SHALL equal latched code[index], each bit held for exactly UNIT_DIV cycles; index decrements after each unit.
REQ-016 After bit 0 completes: SHALL enter GAP with gap count CHAR_GAP, or IDLE directly when CHAR_GAP==0.
REQ-017 In GAP, key SHALL be 0 for gap count x UNIT_DIV cycles, then return to IDLE.
REQ-018 Total busy time for a non-space code SHALL be (msb_index+1+CHAR_GAP) x UNIT_DIV cycles.
REQ-019 Latency: key SHALL reflect the first pattern bit on the cycle after the transfer edge.
REQ-020 code and code_valid changes while busy SHALL be ignored; no queuing.
REQ-021 The unit counter SHALL wrap to 0 at UNIT_DIV-1 and SHALL be cleared on every state entry.

Reset
REQ-022 Asserting rst at any time, including mid-character, SHALL immediately force state IDLE, key=0, busy=0, code_ready=1, counters and latched code to 0.
REQ-023 After rst deasserts, the first transfer SHALL be accepted on the first rising edge with code_valid=1.

Configuration
REQ-024 With macro MORSE_TX_TONE_EN defined: SHALL add parameter TONE_DIV (default 6250) and output tone (1 bit), a square wave toggling every TONE_DIV cycles while key=1, held 0 and divider cleared while key=0 or in reset.
REQ-025 Without MORSE_TX_TONE_EN: tone port, TONE_DIV and the divider SHALL not exist; all other behaviour identical.

Structure
REQ-026 State enum, default UNIT_DIV/CHAR_GAP/WORD_GAP values and code width 24 SHALL live in shared package morse_pkg.
REQ-027 Highest-set-bit detection SHALL be a combinational sub-module morse_msb (24-bit in, 5-bit index out, zero-flag out).

Verification (UNIT_DIV=4, CHAR_GAP=3, WORD_GAP=7)
REQ-028 code=0x2E ('A' pattern 0101110) -> key sequence 1,0,1,1,1,0 each 4 cycles, then 12 cycles key=0, busy for 36 cycles total.
REQ-029 code=0x000002 ('E') -> key=1 for 4 cycles, 0 for 4 cycles, 0 for 12 cycles, code_ready returns after 20 cycles.
REQ-030 code=0x000000 (space) -> key=0, busy=1 for 28 cycles, then code_ready=1.
REQ-031 Second code_valid pulse with a different code during SEND -> ignored; output matches first code only.
REQ-032 rst pulse at cycle 10 of 'A' -> key=0, busy=0, code_ready=1 same cycle; next 'E' transfer sends correctly.
REQ-033 With MORSE_TX_TONE_EN, TONE_DIV=2 -> tone toggles every 2 cycles only during key=1, 0 otherwise.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and defaults for the Morse keyer: state encoding, code width, timing defaults.
package morse_pkg;

    localparam int unsigned CodeW = 24;
    localparam int unsigned IdxW  = 5;
    localparam int unsigned CntW  = 24;
    localparam int unsigned GapW  = 4;

    localparam int unsigned UNIT_DIV_DEFAULT = 5000000;
    localparam int unsigned CHAR_GAP_DEFAULT = 3;
    localparam int unsigned WORD_GAP_DEFAULT = 7;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

endpackage

// File: rtl/morse_tx_if.sv
// Valid/ready code-transfer bundle between the character encoder (master) and the keyer (slave).
interface morse_tx_if;
    import morse_pkg::*;

    logic [CodeW-1:0] code;
    logic             code_valid;
    logic             code_ready;

    modport master (output code, output code_valid, input code_ready);
    modport slave (input code, input code_valid, output code_ready);

endinterface

// File: rtl/morse_msb.sv
// Highest-set-bit locator for a code word; zero_o flags an all-zero (space) code.
module morse_msb
    import morse_pkg::*;
(
    input  logic [CodeW-1:0] code_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             zero_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < CodeW; i++) begin
            if (code_i[i]) idx_o = i[IdxW-1:0];
        end
    end

    assign zero_o = ~|code_i;

endmodule

// File: rtl/morse_tx.sv
// Morse keyer: plays a right-aligned on/off pattern one bit per time unit, then a key-off gap.
// Defining MORSE_TX_TONE_EN adds TONE_DIV and a gated square-wave tone output.
module morse_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_DIV = UNIT_DIV_DEFAULT,
    parameter int unsigned CHAR_GAP = CHAR_GAP_DEFAULT,
    parameter int unsigned WORD_GAP = WORD_GAP_DEFAULT
`ifdef MORSE_TX_TONE_EN
    ,
    parameter int unsigned TONE_DIV = 6250
`endif
) (
    input  logic      clk,
    input  logic      rst,
    morse_tx_if.slave bus,
    output logic      key_o,
    output logic      busy_o
`ifdef MORSE_TX_TONE_EN
    ,
    output logic      tone_o
`endif
);

    localparam logic [CntW-1:0] UnitLast = CntW'(UNIT_DIV - 1);
    localparam logic [GapW-1:0] CharGap  = GapW'(CHAR_GAP);
    localparam logic [GapW-1:0] WordGap  = GapW'(WORD_GAP);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [CodeW-1:0] code_q, code_d;

    logic [IdxW-1:0] msb_idx;
    logic            code_zero;
    logic            unit_done;

    morse_msb u_msb (
        .code_i (bus.code),
        .idx_o  (msb_idx),
        .zero_o (code_zero)
    );

    assign unit_done = (cnt_q == UnitLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        code_d  = code_q;
        case (state_q)
            StIdle: begin
                if (bus.code_valid) begin
                    cnt_d = '0;
                    if (code_zero) begin
                        state_d = StGap;
                        gap_d   = WordGap;
                    end else begin
                        state_d = StSend;
                        code_d  = bus.code;
                        idx_d   = msb_idx;
                    end
                end
            end
            StSend: begin
                if (unit_done) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        if (CHAR_GAP == 0) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StGap;
                            gap_d   = CharGap;
                        end
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (unit_done) begin
                    cnt_d = '0;
                    gap_d = gap_q - 1'b1;
                    if (gap_q == GapW'(1)) state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            code_q  <= code_d;
        end
    end

    // Outputs decode straight from state so reset clears them without waiting for a clock.
    assign bus.code_ready = (state_q == StIdle);
    assign busy_o         = (state_q != StIdle);
    assign key_o          = (state_q == StSend) && code_q[idx_q];

`ifdef MORSE_TX_TONE_EN
    logic [31:0] tdiv_q, tdiv_d;
    logic        tone_q, tone_d;

    always_comb begin
        tdiv_d = '0;
        tone_d = 1'b0;
        if (key_o) begin
            if (tdiv_q == TONE_DIV - 1) begin
                tone_d = ~tone_q;
            end else begin
                tdiv_d = tdiv_q + 1'b1;
                tone_d = tone_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdiv_q <= '0;
            tone_q <= 1'b0;
        end else begin
            tdiv_q <= tdiv_d;
            tone_q <= tone_d;
        end
    end

    // Gate with key so the tone is silent on the very cycle key drops.
    assign tone_o = tone_q & key_o;
`endif

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx at UNIT_DIV=4, CHAR_GAP=3, WORD_GAP=7 (TONE_DIV=2 when enabled).
module tb_morse_tx;
    import morse_pkg::*;

    localparam int unsigned Unit = 4;

    logic clk = 1'b0;
    logic rst;
    logic key;
    logic busy;
`ifdef MORSE_TX_TONE_EN
    logic tone;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    morse_tx_if bus_if ();

    morse_tx #(
        .UNIT_DIV (Unit),
        .CHAR_GAP (3),
        .WORD_GAP (7)
`ifdef MORSE_TX_TONE_EN
        ,
        .TONE_DIV (2)
`endif
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if),
        .key_o  (key),
        .busy_o (busy)
`ifdef MORSE_TX_TONE_EN
        ,
        .tone_o (tone)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // pat holds the expected key level per unit (MSB = first unit), gap units included.
    task automatic run_char(input string tag, input logic [23:0] c, input logic [31:0] pat,
                            input int units, input int intf, input int rst_at);
        logic exp_key;
        int   run;
        int   total;
        total = units * Unit;
        @(negedge clk);
        check($sformatf("%s pre-ready", tag), {31'd0, bus_if.code_ready}, 32'd1);
        bus_if.code       = c;
        bus_if.code_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.code_valid = 1'b0;
        bus_if.code       = 24'hABCDEF;
        run = 0;
        for (int k = 0; k <= total; k++) begin
            @(negedge clk);
            exp_key = (k < total) ? pat[units - 1 - k / Unit] : 1'b0;
            check($sformatf("%s key@%0d", tag, k), {31'd0, key}, {31'd0, exp_key});
            check($sformatf("%s busy@%0d", tag, k), {31'd0, busy}, (k < total) ? 32'd1 : 32'd0);
            check($sformatf("%s ready@%0d", tag, k), {31'd0, bus_if.code_ready},
                  (k < total) ? 32'd0 : 32'd1);
`ifdef MORSE_TX_TONE_EN
            if (exp_key) begin
                check($sformatf("%s tone@%0d", tag, k), {31'd0, tone}, 32'((run / 2) % 2));
                run++;
            end else begin
                check($sformatf("%s tone@%0d", tag, k), {31'd0, tone}, 32'd0);
                run = 0;
            end
`endif
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check($sformatf("%s rst key", tag), {31'd0, key}, 32'd0);
                check($sformatf("%s rst busy", tag), {31'd0, busy}, 32'd0);
                check($sformatf("%s rst ready", tag), {31'd0, bus_if.code_ready}, 32'd1);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (k == intf) begin
                bus_if.code       = 24'h000002;
                bus_if.code_valid = 1'b1;
            end
            if (k == intf + 1) bus_if.code_valid = 1'b0;
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus_if.code       = '0;
        bus_if.code_valid = 1'b0;
        @(negedge clk);
        check("reset key", {31'd0, key}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset ready", {31'd0, bus_if.code_ready}, 32'd1);
`ifdef MORSE_TX_TONE_EN
        check("reset tone", {31'd0, tone}, 32'd0);
`endif
        rst = 1'b0;

        // 'A' 101110 + 3 gap units = 36 cycles
        run_char("A", 24'h00002E, 32'b101110_000, 9, -1, -1);
        // 'E' 10 + 3 gap units = 20 cycles
        run_char("E", 24'h000002, 32'b10_000, 5, -1, -1);
        // space: 7 units key-off
        run_char("SPACE", 24'h000000, 32'b0000000, 7, -1, -1);
        // single bit at index 0
        run_char("DOT0", 24'h000001, 32'b1_000, 4, -1, -1);
        // msb at bit 23: 1, 22 zeros, 1, then gap
        run_char("MSB23", 24'h800001, 32'h0400_0008, 27, -1, -1);
        // second code offered mid-SEND must be ignored
        run_char("A-ign", 24'h00002E, 32'b101110_000, 9, 5, -1);
        // reset at cycle 10 of 'A', then a clean 'E'
        run_char("A-rst", 24'h00002E, 32'b101110_000, 9, -1, 10);
        run_char("E-post", 24'h000002, 32'b10_000, 5, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
